// File: rtl/carrier_counter_pkg.sv
// Shared PWM types for the carrier / event counter chain.
`ifndef CARRIER_COUNTER_PKG_DEFS
`define CARRIER_COUNTER_PKG_DEFS
`define CARRIER_WIDTH 16
`define EVTCOUNT_WIDTH 16
`endif

package carrier_counter_pkg;

   localparam int CARR_W_DEFAULT = `CARRIER_WIDTH;
   localparam int EVT_W_DEFAULT  = `EVTCOUNT_WIDTH;

   typedef enum logic {
      PWM_OFF = 1'b0,
      PWM_ON  = 1'b1
   } _pwm_onoff;

   typedef enum logic [1:0] {
      NO_COUNT     = 2'd0,
      UP_COUNT     = 2'd1,
      DOWN_COUNT   = 2'd2,
      UPDOWN_COUNT = 2'd3
   } _count_mode;

   typedef enum logic [1:0] {
      MASK_NONE = 2'd0,
      MASK_MAX  = 2'd1,
      MASK_MIN  = 2'd2,
      MASK_BOTH = 2'd3
   } _mask_mode;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } _carr_dir;

endpackage

// File: rtl/carrier_counter_period_shadow.sv
// Double-buffered period: pending flag plus the active period register.
module carrier_counter_period_shadow
   import carrier_counter_pkg::*;
#(
   parameter int W = CARR_W_DEFAULT
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic         i_arm,
   input  logic         i_wrap,
   input  logic [W-1:0] i_period_in,
   output logic [W-1:0] o_period_act,
   output logic [W-1:0] o_period_next
);

   logic [W-1:0] r_period_act;
   logic         r_pending;

   // An arm on the wrap cycle itself re-arms for the following wrap.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_period_act <= {W{1'b0}};
         r_pending    <= 1'b0;
      end else if (i_load) begin
         r_period_act <= i_period_in;
         r_pending    <= 1'b0;
      end else begin
         if (i_wrap && r_pending) begin
            r_period_act <= i_period_in;
         end else begin
            r_period_act <= r_period_act;
         end
         if (i_arm) begin
            r_pending <= 1'b1;
         end else if (i_wrap) begin
            r_pending <= 1'b0;
         end else begin
            r_pending <= r_pending;
         end
      end
   end

   assign o_period_act  = r_period_act;
   assign o_period_next = r_pending ? i_period_in : r_period_act;

endmodule

// File: rtl/carrier_counter.sv
// PWM carrier generator: up / down / up-down counting with phase sync,
// double-buffered period and single-cycle boundary events.
module carrier_counter
   import carrier_counter_pkg::*;
#(
   parameter int CARR_WIDTH = CARR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  _pwm_onoff             pwm_onoff,
   input  _count_mode            countmode,
   input  logic [CARR_WIDTH-1:0] period_in,
   input  logic [CARR_WIDTH-1:0] phase_in,
   input  logic                  sync_in,
   input  logic                  update_req,
   output logic [CARR_WIDTH-1:0] carrier,
   output logic [CARR_WIDTH-1:0] period_act,
   output logic                  max_event,
   output logic                  min_event,
   output logic                  carr_event
);

   localparam logic [CARR_WIDTH-1:0] C_ZERO = {CARR_WIDTH{1'b0}};
   localparam logic [CARR_WIDTH-1:0] C_ONE  = {{(CARR_WIDTH-1){1'b0}}, 1'b1};

   logic [CARR_WIDTH-1:0] r_carrier;
   _carr_dir              r_dir;
   logic [CARR_WIDTH-1:0] w_period_act;
   logic [CARR_WIDTH-1:0] w_period_next;
   logic                  w_off;
   logic                  w_counting;
   logic                  w_at_min;
   logic                  w_at_max;
   logic                  w_wrap;

   assign w_off      = (pwm_onoff == PWM_OFF);
   assign w_counting = !reset && !w_off && !sync_in && (countmode != NO_COUNT);
   assign w_at_min   = (r_carrier == C_ZERO);
   assign w_at_max   = (r_carrier == w_period_act);

   // Wrap point where a pending period is taken over.
   always_comb begin
      w_wrap = 1'b0;
      if (w_counting) begin
         case (countmode)
            UP_COUNT:     w_wrap = w_at_max;
            DOWN_COUNT:   w_wrap = w_at_min;
            UPDOWN_COUNT: w_wrap = w_at_min;
            default:      w_wrap = 1'b0;
         endcase
      end else begin
         w_wrap = 1'b0;
      end
   end

   carrier_counter_period_shadow #(.W(CARR_WIDTH)) u_period_shadow (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_load        (w_off),
      .i_arm         (update_req),
      .i_wrap        (w_wrap),
      .i_period_in   (period_in),
      .o_period_act  (w_period_act),
      .o_period_next (w_period_next)
   );

   // Counter/direction FSM; UP and DOWN modes keep dir aligned with the count.
   always_ff @(posedge clk) begin
      if (reset || w_off) begin
         r_carrier <= C_ZERO;
         r_dir     <= DIR_UP;
      end else if (sync_in) begin
         r_carrier <= (phase_in > w_period_act) ? w_period_act : phase_in;
         r_dir     <= DIR_UP;
      end else begin
         case (countmode)
            UP_COUNT: begin
               r_dir     <= DIR_UP;
               r_carrier <= w_at_max ? C_ZERO : r_carrier + C_ONE;
            end
            DOWN_COUNT: begin
               r_dir     <= DIR_DOWN;
               r_carrier <= w_at_min ? w_period_next : r_carrier - C_ONE;
            end
            UPDOWN_COUNT: begin
               if (w_at_min) begin
                  r_carrier <= (w_period_next == C_ZERO) ? C_ZERO : C_ONE;
                  r_dir     <= DIR_UP;
               end else if (w_at_max) begin
                  r_carrier <= r_carrier - C_ONE;
                  r_dir     <= DIR_DOWN;
               end else if (r_dir == DIR_UP) begin
                  r_carrier <= r_carrier + C_ONE;
                  r_dir     <= r_dir;
               end else begin
                  r_carrier <= r_carrier - C_ONE;
                  r_dir     <= r_dir;
               end
            end
            default: begin
               r_carrier <= r_carrier;
               r_dir     <= r_dir;
            end
         endcase
      end
   end

   assign carrier    = r_carrier;
   assign period_act = w_period_act;
   assign max_event  = w_counting && w_at_max;
   assign min_event  = w_counting && w_at_min;
   assign carr_event = max_event || min_event;

endmodule
